// File: rtl/csr_if.sv
// csr_if: CSR access, trap and redirect bundle between core and csr_unit.
// master = core side (IDU/retire), slave = csr_unit.
interface csr_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            wr_suppress;
    logic [XLEN-1:0] csr_rdata;
    logic            illegal;
    logic            retire;
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            mret;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output req_valid,
        output csr_op,
        output csr_addr,
        output csr_wdata,
        output wr_suppress,
        output retire,
        output trap_valid,
        output trap_cause,
        output trap_pc,
        output mret,
        input  csr_rdata,
        input  illegal,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  req_valid,
        input  csr_op,
        input  csr_addr,
        input  csr_wdata,
        input  wr_suppress,
        input  retire,
        input  trap_valid,
        input  trap_cause,
        input  trap_pc,
        input  mret,
        output csr_rdata,
        output illegal,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file (mstatus, mtvec, mscratch, mepc, mcause,
// mcycle/minstret, mvendorid, marchid) with trap/mret redirect.
// Ports: clk, rst (async, active-high), bus (csr_if.slave):
//   req_valid/csr_op/csr_addr/csr_wdata/wr_suppress -> csr_rdata, illegal
//   retire, trap_valid/trap_cause/trap_pc, mret -> redirect_valid/redirect_pc
module csr_unit #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800,
    parameter logic [XLEN-1:0] MARCHID       = 32'h0000_0000,
    parameter bit              VECTORED_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    csr_if.slave bus
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    // mtvec bit 1 never holds a value; bit 0 only when vectored mode exists
    localparam logic [XLEN-1:0] MTVEC_MASK =
        VECTORED_EN ? ~XLEN'(2) : ~XLEN'(3);

    localparam logic [2*XLEN-1:0] CNT_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};

    // architectural state
    logic              mie_q;
    logic              mpie_q;
    logic [XLEN-1:0]   mtvec_q;
    logic [XLEN-1:0]   mscratch_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   mcause_q;
    logic [2*XLEN-1:0] mcycle_q;
    logic [2*XLEN-1:0] minstret_q;

    // address decode
    logic hit_mstatus;
    logic hit_mtvec;
    logic hit_mscratch;
    logic hit_mepc;
    logic hit_mcause;
    logic hit_mcycle;
    logic hit_mcycleh;
    logic hit_minstret;
    logic hit_minstreth;
    logic hit_mvendorid;
    logic hit_marchid;

    assign hit_mstatus   = bus.csr_addr == A_MSTATUS;
    assign hit_mtvec     = bus.csr_addr == A_MTVEC;
    assign hit_mscratch  = bus.csr_addr == A_MSCRATCH;
    assign hit_mepc      = bus.csr_addr == A_MEPC;
    assign hit_mcause    = bus.csr_addr == A_MCAUSE;
    assign hit_mcycle    = bus.csr_addr == A_MCYCLE;
    assign hit_mcycleh   = bus.csr_addr == A_MCYCLEH;
    assign hit_minstret  = bus.csr_addr == A_MINSTRET;
    assign hit_minstreth = bus.csr_addr == A_MINSTRETH;
    assign hit_mvendorid = bus.csr_addr == A_MVENDORID;
    assign hit_marchid   = bus.csr_addr == A_MARCHID;

    // mstatus view: MPP hardwired to M-mode, only MIE/MPIE live
    logic [XLEN-1:0] mstatus_rd;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_q;
    end

    // read mux
    logic            impl;
    logic [XLEN-1:0] old_val;

    always_comb begin
        impl    = 1'b1;
        old_val = '0;
        unique case (1'b1)
            hit_mstatus:   old_val = mstatus_rd;
            hit_mtvec:     old_val = mtvec_q;
            hit_mscratch:  old_val = mscratch_q;
            hit_mepc:      old_val = mepc_q;
            hit_mcause:    old_val = mcause_q;
            hit_mcycle:    old_val = mcycle_q[XLEN-1:0];
            hit_mcycleh:   old_val = mcycle_q[2*XLEN-1:XLEN];
            hit_minstret:  old_val = minstret_q[XLEN-1:0];
            hit_minstreth: old_val = minstret_q[2*XLEN-1:XLEN];
            hit_mvendorid: old_val = '0;
            hit_marchid:   old_val = MARCHID;
            default:       impl    = 1'b0;
        endcase
    end

    // access qualification
    logic acc;
    logic no_wr;
    logic ro_space;
    logic ill;
    logic wr_en;

    assign acc      = bus.req_valid & (bus.csr_op != OP_NONE);
    // set/clear with a zero operand is a pure read
    assign no_wr    = (bus.csr_op != OP_RW) & bus.wr_suppress;
    assign ro_space = bus.csr_addr[11:8] == 4'hF;
    assign ill      = acc & (~impl | (ro_space & ~no_wr));
    assign wr_en    = acc & ~ill & ~no_wr
                    & ~bus.trap_valid & ~bus.mret;

    assign bus.illegal   = ill;
    assign bus.csr_rdata = (acc & ~ill) ? old_val : '0;

    // write value before per-CSR masking
    logic [XLEN-1:0] wval;

    always_comb begin
        wval = bus.csr_wdata;
        unique case (bus.csr_op)
            OP_RS:   wval = old_val | bus.csr_wdata;
            OP_RC:   wval = old_val & ~bus.csr_wdata;
            default: wval = bus.csr_wdata;
        endcase
    end

    // redirect target
    logic [XLEN-1:0] tvec_base;
    logic            vec_irq;
    logic [XLEN-1:0] trap_tgt;

    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    // mode bits can only be 00 or 01, so bit 0 alone selects vectored
    assign vec_irq   = mtvec_q[0] & bus.trap_cause[XLEN-1];
    assign trap_tgt  = vec_irq
                     ? tvec_base + {bus.trap_cause[XLEN-3:0], 2'b00}
                     : tvec_base;

    always_comb begin
        bus.redirect_valid = bus.trap_valid | bus.mret;
        bus.redirect_pc    = '0;
        if (bus.trap_valid) begin
            bus.redirect_pc = trap_tgt;
        end else if (bus.mret) begin
            bus.redirect_pc = mepc_q;
        end
    end

    // trap, mret and plain CSR writes; trap wins over mret wins over write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= MSTATUS_RESET[3];
            mpie_q     <= MSTATUS_RESET[7];
            mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (bus.trap_valid) begin
            mepc_q   <= {bus.trap_pc[XLEN-1:2], 2'b00};
            mcause_q <= bus.trap_cause;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (bus.mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en) begin
            unique case (1'b1)
                hit_mstatus: begin
                    mie_q  <= wval[3];
                    mpie_q <= wval[7];
                end
                hit_mtvec:    mtvec_q    <= wval & MTVEC_MASK;
                hit_mscratch: mscratch_q <= wval;
                hit_mepc:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
                hit_mcause:   mcause_q   <= wval;
                default: ;
            endcase
        end
    end

    // a half written this cycle replaces the count, suppressing the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q <= '0;
        end else if (wr_en & hit_mcycle) begin
            mcycle_q[XLEN-1:0] <= wval;
        end else if (wr_en & hit_mcycleh) begin
            mcycle_q[2*XLEN-1:XLEN] <= wval;
        end else begin
            mcycle_q <= mcycle_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minstret_q <= '0;
        end else if (wr_en & hit_minstret) begin
            minstret_q[XLEN-1:0] <= wval;
        end else if (wr_en & hit_minstreth) begin
            minstret_q[2*XLEN-1:XLEN] <= wval;
        end else if (bus.retire) begin
            minstret_q <= minstret_q + CNT_ONE;
        end
    end

    // pc is word aligned in mepc, low bits never observed
    logic [1:0] unused_pc_bits;
    assign unused_pc_bits = bus.trap_pc[1:0];
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed + random stimulus, reference model and
// scoreboard queue checked by an independent negedge monitor.
module tb_csr_unit;
    localparam int          XLEN      = 32;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam logic [31:0] ARCH_ID   = 32'h1234_5678;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_if #(.XLEN(XLEN)) bus ();

    csr_unit #(
        .XLEN(XLEN),
        .MTVEC_RESET(MTVEC_RST),
        .MSTATUS_RESET(32'h0000_1800),
        .MARCHID(ARCH_ID),
        .VECTORED_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        ill;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_mie      = 1'b0;
        m_mpie     = 1'b0;
        m_mtvec    = MTVEC_RST & ~32'h2;
        m_mscratch = '0;
        m_mepc     = '0;
        m_mcause   = '0;
        m_cyc      = '0;
        m_ins      = '0;
    endtask

    function automatic void m_read(input logic [11:0] a,
                                   output logic [31:0] v,
                                   output bit hit);
        hit = 1'b1;
        v   = '0;
        case (a)
            12'h300: v = 32'h1800 + (m_mie ? 8 : 0) + (m_mpie ? 128 : 0);
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            12'hF11: v = '0;
            12'hF12: v = ARCH_ID;
            default: hit = 1'b0;
        endcase
    endfunction

    task automatic step(input bit r, input bit v, input logic [1:0] op,
                        input logic [11:0] a, input logic [31:0] wd,
                        input bit sup, input bit ret, input bit trap,
                        input logic [31:0] cause, input logic [31:0] pc,
                        input bit mr, input string nm);
        exp_t        e;
        logic [31:0] old, nv, tgt;
        bit          hit, acc, nowr, ill, wc, wi;
        @(posedge clk);
        #1;
        rst             = r;
        bus.req_valid   = v;
        bus.csr_op      = op;
        bus.csr_addr    = a;
        bus.csr_wdata   = wd;
        bus.wr_suppress = sup;
        bus.retire      = ret;
        bus.trap_valid  = trap;
        bus.trap_cause  = cause;
        bus.trap_pc     = pc;
        bus.mret        = mr;
        if (r) model_reset();
        m_read(a, old, hit);
        acc  = v && (op != 2'b00);
        nowr = (op != 2'b01) && sup;
        ill  = acc && (!hit || (a[11:8] == 4'hF && !nowr));
        tgt  = m_mtvec & ~32'h3;
        if (m_mtvec[1:0] == 2'b01 && cause[31])
            tgt = tgt + (cause & 32'h7FFF_FFFF) * 4;
        e.name  = nm;
        e.rdata = (acc && !ill) ? old : 32'h0;
        e.ill   = ill;
        e.rv    = trap || mr;
        e.rpc   = trap ? tgt : m_mepc;
        q.push_back(e);
        if (!r) begin
            wc = 1'b0;
            wi = 1'b0;
            if (trap) begin
                m_mepc   = pc & ~32'h3;
                m_mcause = cause;
                m_mpie   = m_mie;
                m_mie    = 1'b0;
            end else if (mr) begin
                m_mie  = m_mpie;
                m_mpie = 1'b1;
            end else if (acc && !ill && !nowr) begin
                case (op)
                    2'b01:   nv = wd;
                    2'b10:   nv = old | wd;
                    default: nv = old & ~wd;
                endcase
                case (a)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec    = nv & ~32'h2;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc     = nv & ~32'h3;
                    12'h342: m_mcause   = nv;
                    12'hB00: begin m_cyc[31:0]  = nv; wc = 1'b1; end
                    12'hB80: begin m_cyc[63:32] = nv; wc = 1'b1; end
                    12'hB02: begin m_ins[31:0]  = nv; wi = 1'b1; end
                    12'hB82: begin m_ins[63:32] = nv; wi = 1'b1; end
                    default: ;
                endcase
            end
            if (!wc) m_cyc = m_cyc + 64'd1;
            if (ret && !wi) m_ins = m_ins + 64'd1;
        end
    endtask

    task automatic idle(input bit ret = 1'b0);
        step(0, 0, 2'b00, 12'h0, 0, 0, ret, 0, 0, 0, 0, "idle");
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input bit sup,
                       input string nm);
        step(0, 1, op, a, wd, sup, 0, 0, 0, 0, 0, nm);
    endtask

    task automatic rd(input logic [11:0] a, input string nm);
        csr(2'b10, a, 32'h0, 1'b1, nm);
    endtask

    // monitor: one expected record per driven cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, " rdata"}, bus.csr_rdata, e.rdata);
            chk({e.name, " illegal"}, 32'(bus.illegal), 32'(e.ill));
            chk({e.name, " redirect_valid"}, 32'(bus.redirect_valid),
                32'(e.rv));
            if (e.rv) chk({e.name, " redirect_pc"}, bus.redirect_pc, e.rpc);
        end
    end

    logic [11:0] addrs [11] = '{12'h300, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'hB00, 12'hB80, 12'hB02,
                                12'hB82, 12'hF11, 12'hF12};

    initial begin
        bus.req_valid   = 1'b0;
        bus.csr_op      = 2'b00;
        bus.csr_addr    = '0;
        bus.csr_wdata   = '0;
        bus.wr_suppress = 1'b0;
        bus.retire      = 1'b0;
        bus.trap_valid  = 1'b0;
        bus.trap_cause  = '0;
        bus.trap_pc     = '0;
        bus.mret        = 1'b0;
        model_reset();

        step(1, 1, 2'b10, 12'h300, 0, 1, 0, 0, 0, 0, 0, "rst mstatus");
        step(1, 1, 2'b10, 12'hB00, 0, 1, 0, 0, 0, 0, 0, "rst mcycle");
        idle();
        rd(12'h300, "mstatus reset");
        rd(12'h305, "mtvec reset");
        rd(12'hF12, "marchid");

        csr(2'b01, 12'h305, 32'h8000_0001, 0, "rw mtvec");
        rd(12'h305, "mtvec rb");
        csr(2'b01, 12'h340, 32'h0000_000F, 0, "rw mscratch");
        csr(2'b10, 12'h340, 32'h0000_00F0, 0, "rs mscratch");
        rd(12'h340, "mscratch rs rb");
        csr(2'b11, 12'h340, 32'h0000_0003, 0, "rc mscratch");
        rd(12'h340, "mscratch rc rb");

        csr(2'b10, 12'h300, 32'h8, 0, "set mie");
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'd11, 32'h8000_0102, 0, "trap ecall");
        rd(12'h341, "mepc after trap");
        rd(12'h300, "mstatus after trap");
        rd(12'h342, "mcause after trap");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mret");
        rd(12'h300, "mstatus after mret");
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0007, 32'h100, 0, "trap vec");

        csr(2'b01, 12'hF11, 32'h5, 0, "rw mvendorid");
        rd(12'hF11, "mvendorid rb");
        csr(2'b10, 12'h7C0, 32'h1, 0, "rs unimpl");
        csr(2'b10, 12'hF11, 32'h0, 1, "rs mvendorid sup");

        step(0, 1, 2'b01, 12'h340, 32'hDEAD_BEEF, 0, 0, 1, 32'd2,
             32'h44, 0, "trap+write");
        rd(12'h340, "mscratch kept");
        step(0, 1, 2'b01, 12'h340, 32'hCAFE_0000, 0, 0, 0, 0, 0, 1,
             "mret+write");
        rd(12'h340, "mscratch kept2");

        csr(2'b01, 12'hB00, 32'hFFFF_FFFF, 0, "rw mcycle");
        csr(2'b01, 12'hB80, 32'hFFFF_FFFF, 0, "rw mcycleh");
        idle();
        rd(12'hB00, "mcycle wrap");
        rd(12'hB80, "mcycleh wrap");
        csr(2'b01, 12'hB02, 32'h0, 0, "rw minstret");
        csr(2'b01, 12'hB82, 32'h0, 0, "rw minstreth");
        for (int i = 0; i < 5; i++) idle(1'b1);
        rd(12'hB02, "minstret 5");

        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            bit          r;
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom)
                : addrs[$urandom_range(0, 10)];
            r = (i == 200 || i == 201);
            step(r, $urandom_range(0, 3) != 0, 2'($urandom), a,
                 $urandom, $urandom_range(0, 3) == 0,
                 1'($urandom), $urandom_range(0, 15) == 0,
                 $urandom, $urandom, $urandom_range(0, 15) == 0,
                 r ? "rnd rst" : "rnd");
        end

        idle();
        idle();
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
